// File: rtl/adg711_seq_ctrl.sv
// adg711_seq_ctrl: multi-channel ADG711 switch sequencer.
// Per-channel divider, mode select and break-before-make output stage.
module adg711_seq_ctrl #(
  parameter int NCH        = 4,
  parameter int CW         = 21,
  parameter int CHW        = 2,
  parameter int DEF_PERIOD = 50,
  parameter int DEAD       = 3
) (
  input  logic           CP,
  input  logic           CR,
  input  logic [NCH-1:0] in,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [1:0]     cfg_mode,
  input  logic           sync,
  output logic [NCH-1:0] sw,
  output logic [NCH-1:0] tc
);

  typedef enum logic [1:0] {
    M_OFF  = 2'd0,
    M_TOG  = 2'd1,
    M_PUL  = 2'd2,
    M_PASS = 2'd3
  } mode_t;

  localparam logic [CW-1:0] DEFP  = CW'(DEF_PERIOD);
  localparam logic [7:0]    DEADV = 8'(DEAD);

  mode_t         mode   [NCH];
  logic [CW-1:0] period [NCH];
  logic [CW-1:0] cnt    [NCH];
  logic [7:0]    dcnt   [NCH];
  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] rawe;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] wsel;

  always_comb begin
    hit  = '0;
    rawe = '0;
    wsel = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = (cnt[i] == period[i]);
      rawe[i] = (mode[i] == M_PASS) ? s2[i] : raw[i];
      wsel[i] = cfg_we && (cfg_ch == CHW'(i));
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      for (int i = 0; i < NCH; i++) begin
        period[i] <= DEFP;
        mode[i]   <= M_OFF;
        cnt[i]    <= '0;
        dcnt[i]   <= '0;
      end
      raw <= '0;
      s1  <= '0;
      s2  <= '0;
      sw  <= '0;
      tc  <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        unique case (mode[i])
          M_TOG: begin
            cnt[i] <= hit[i] ? '0 : cnt[i] + CW'(1);
            tc[i]  <= hit[i];
            raw[i] <= raw[i] ^ hit[i];
          end
          M_PUL: begin
            cnt[i] <= hit[i] ? '0 : cnt[i] + CW'(1);
            tc[i]  <= hit[i];
            raw[i] <= hit[i];
          end
          M_OFF, M_PASS: begin
            cnt[i] <= '0;
            tc[i]  <= 1'b0;
            raw[i] <= 1'b0;
          end
          default: begin
            cnt[i] <= '0;
            tc[i]  <= 1'b0;
            raw[i] <= 1'b0;
          end
        endcase
        // pulse mode bypasses dead time
        if (mode[i] == M_PUL) begin
          sw[i]   <= raw[i];
          dcnt[i] <= '0;
        end else if (!rawe[i]) begin
          sw[i]   <= 1'b0;
          dcnt[i] <= '0;
        end else if (dcnt[i] < DEADV) begin
          dcnt[i] <= dcnt[i] + 8'd1;
        end else begin
          sw[i] <= 1'b1;
        end
        if (wsel[i]) begin
          period[i] <= cfg_period;
          mode[i]   <= mode_t'(cfg_mode);
        end
        if (wsel[i] || sync) begin
          cnt[i]  <= '0;
          raw[i]  <= 1'b0;
          dcnt[i] <= '0;
          tc[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adg711_seq_ctrl.sv
// tb_adg711_seq_ctrl: directed bench for adg711_seq_ctrl.
// CHW=3 so that channel index 4 is out of range.
module tb_adg711_seq_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 21;
  localparam int CHW = 3;

  logic           CP = 1'b0;
  logic           CR;
  logic [NCH-1:0] in_v;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [1:0]     cfg_mode;
  logic           sync;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] tc;

  int checks = 0;
  int errors = 0;

  logic [63:0] o_a;
  logic [63:0] o_b;
  logic [63:0] e_a;
  logic [63:0] e_b;
  logic [NCH-1:0] acc;

  adg711_seq_ctrl #(
    .NCH(NCH), .CW(CW), .CHW(CHW),
    .DEF_PERIOD(50), .DEAD(3)
  ) dut (
    .CP(CP), .CR(CR), .in(in_v),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .sync(sync),
    .sw(sw), .tc(tc)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int per,
                    input int md);
    cfg_we     = 1'b1;
    cfg_ch     = CHW'(ch);
    cfg_period = CW'(per);
    cfg_mode   = 2'(md);
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    CR = 1'b1; in_v = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_period = '0;
    cfg_mode = '0; sync = 1'b0;
    tick();
    tick();
    CR = 1'b0;
    chk("rst_sw", 64'(sw), 64'd0);
    chk("rst_tc", 64'(tc), 64'd0);
    chk("rst_per0", 64'(dut.period[0]), 64'd50);
    acc = '0;
    repeat (10) begin
      tick();
      acc = acc | sw | tc;
    end
    chk("idle_quiet", 64'(acc), 64'd0);

    // ch0 toggle, period 4
    wr(0, 4, 1);
    o_a = '0; o_b = '0; e_a = '0; e_b = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      o_a[k-1] = tc[0];
      o_b[k-1] = sw[0];
      e_a[k-1] = (k % 5 == 0);
      e_b[k-1] = (k == 9 || k == 10 ||
                  k == 19 || k == 20);
    end
    chk("tog_tc0", o_a, e_a);
    chk("tog_sw0", o_b, e_b);

    // ch1 pulse, period 9
    wr(1, 9, 2);
    o_a = '0; o_b = '0; e_a = '0; e_b = '0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      o_a[k-1] = tc[1];
      o_b[k-1] = sw[1];
      e_a[k-1] = (k % 10 == 0);
      e_b[k-1] = (k % 10 == 1) && (k > 1);
    end
    chk("pul_tc1", o_a, e_a);
    chk("pul_sw1", o_b, e_b);

    // ch2 pass-through
    wr(2, 0, 3);
    o_a = '0; e_a = '0;
    for (int k = 1; k <= 40; k++) begin
      in_v[2] = (k <= 10) || (k >= 21 && k <= 23);
      tick();
      o_a[k-1] = sw[2];
      e_a[k-1] = (k >= 6 && k <= 12);
    end
    in_v[2] = 1'b0;
    chk("pass_sw2", o_a, e_a);

    // ch0/ch1 toggle, then sync
    wr(0, 4, 1);
    wr(1, 6, 1);
    repeat (26) tick();
    chk("pre_sync_sw1", 64'(sw[1]), 64'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_cnt0", 64'(dut.cnt[0]), 64'd0);
    chk("sync_cnt1", 64'(dut.cnt[1]), 64'd0);
    chk("sync_sw1_hold", 64'(sw[1]), 64'd1);
    o_a = '0; o_b = '0; e_a = '0; e_b = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        chk("sync_sw_fall", 64'(sw[1:0]), 64'd0);
      end
      o_a[k-1] = tc[0];
      o_b[k-1] = tc[1];
      e_a[k-1] = (k == 5);
      e_b[k-1] = (k == 7);
    end
    chk("sync_tc0", o_a, e_a);
    chk("sync_tc1", o_b, e_b);

    // ch3 period 0 toggle: dead time swallows it
    wr(3, 0, 1);
    o_a = '0; o_b = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      o_a[k-1] = tc[3];
      o_b[k-1] = sw[3];
    end
    chk("p0_tc3", o_a, 64'h3ff);
    chk("p0_sw3", o_b, 64'd0);

    // out-of-range channel write
    wr(4, 9, 2);
    chk("oor_per0", 64'(dut.period[0]), 64'd4);
    chk("oor_mode0", 64'(dut.mode[0]), 64'd1);
    chk("oor_per3", 64'(dut.period[3]), 64'd0);
    chk("oor_mode3", 64'(dut.mode[3]), 64'd1);
    o_a = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      o_a[k-1] = tc[3];
    end
    chk("oor_tc3", o_a, 64'h1f);

    // reset wins over write and sync
    CR = 1'b1;
    cfg_we = 1'b1; cfg_ch = '0;
    cfg_period = CW'(7); cfg_mode = 2'd1;
    sync = 1'b1;
    in_v = '1;
    tick();
    CR = 1'b0; cfg_we = 1'b0; sync = 1'b0;
    chk("cr_sw", 64'(sw), 64'd0);
    chk("cr_tc", 64'(tc), 64'd0);
    chk("cr_per0", 64'(dut.period[0]), 64'd50);
    for (int i = 0; i < NCH; i++) begin
      chk("cr_mode", 64'(dut.mode[i]), 64'd0);
    end
    acc = '0;
    repeat (60) begin
      tick();
      acc = acc | sw | tc;
    end
    chk("cr_quiet", 64'(acc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
